// File: rtl/pipelined_decode_ctrl.sv
// Registered MIPS decode stage: one instruction per cycle into a control bundle,
// with load-use bubbles, branch flush, illegal flagging and a HALT drain sequence.
module pipelined_decode_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned LU_BUBBLES   = 1,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned HAZARD_EN    = 1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd,
  output logic [4:0]        shamt,
  output logic [31:0]       imm32,
  output logic [25:0]       jaddr,
  output logic [3:0]        ALUctr,
  output logic [1:0]        ALUSrc,
  output logic [1:0]        RegDst,
  output logic [1:0]        MemToReg,
  output logic              RegWr,
  output logic              dREN,
  output logic              dWEN,
  output logic              Jump,
  output logic              JumpReg,
  output logic              Branch,
  output logic              BranchNEQ,
  output logic              illegal,
  output logic              halt
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'b0000, ALU_SRL = 4'b0001, ALU_ADD = 4'b0010, ALU_SUB  = 4'b0011,
    ALU_AND  = 4'b0100, ALU_OR  = 4'b0101, ALU_XOR = 4'b0110, ALU_NOR  = 4'b0111,
    ALU_SLT  = 4'b1010, ALU_SLTU = 4'b1011
  } aluop_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL  = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDIU = 6'h09,
                         OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C,
                         OP_ORI   = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F,
                         OP_LW    = 6'h23, OP_SW    = 6'h2B, OP_HALT = 6'h3F;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08,
                         FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22,
                         FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25,
                         FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2A,
                         FN_SLTU = 6'h2B;

  state_t            state;
  logic [3:0]        cnt;

  logic [5:0]        op, fn;
  logic [15:0]       imm16;
  logic [REG_AW-1:0] f_rs, f_rt;
  logic              uses_rt, hazard, held, out_free, accept, flush_eff;

  aluop_t            d_alu;
  logic [1:0]        d_alusrc, d_regdst, d_memtoreg;
  logic              d_regwr, d_dren, d_dwen, d_jump, d_jr, d_br, d_bne, d_ill, d_halt, r_alu;
  logic [REG_AW-1:0] d_rs, d_rt, d_rd;
  logic [4:0]        d_shamt;
  logic [31:0]       d_imm;
  logic [25:0]       d_jaddr;

  always_comb begin
    op         = instruction[31:26];
    fn         = instruction[5:0];
    imm16      = instruction[15:0];
    f_rs       = REG_AW'(instruction[25:21]);
    f_rt       = REG_AW'(instruction[20:16]);
    d_rs       = f_rs;
    d_rt       = f_rt;
    d_rd       = REG_AW'(instruction[15:11]);
    d_shamt    = instruction[10:6];
    d_jaddr    = instruction[25:0];
    d_imm      = {{16{imm16[15]}}, imm16};
    d_alu      = ALU_ADD;
    d_alusrc   = 2'd0;
    d_regdst   = 2'd0;
    d_memtoreg = 2'd0;
    d_regwr    = 1'b0;
    d_dren     = 1'b0;
    d_dwen     = 1'b0;
    d_jump     = 1'b0;
    d_jr       = 1'b0;
    d_br       = 1'b0;
    d_bne      = 1'b0;
    d_ill      = 1'b0;
    d_halt     = 1'b0;
    r_alu      = 1'b0;

    case (op)
      OP_ANDI, OP_ORI, OP_XORI: d_imm = {16'h0000, imm16};
      OP_LUI:                   d_imm = {imm16, 16'h0000};
      default: ;
    endcase

    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_ADDU: begin d_alu = ALU_ADD;  r_alu = 1'b1; end
          FN_SUB, FN_SUBU: begin d_alu = ALU_SUB;  r_alu = 1'b1; end
          FN_AND:          begin d_alu = ALU_AND;  r_alu = 1'b1; end
          FN_OR:           begin d_alu = ALU_OR;   r_alu = 1'b1; end
          FN_XOR:          begin d_alu = ALU_XOR;  r_alu = 1'b1; end
          FN_NOR:          begin d_alu = ALU_NOR;  r_alu = 1'b1; end
          FN_SLT:          begin d_alu = ALU_SLT;  r_alu = 1'b1; end
          FN_SLTU:         begin d_alu = ALU_SLTU; r_alu = 1'b1; end
          FN_SLL:          begin d_alu = ALU_SLL;  r_alu = 1'b1; d_alusrc = 2'd2; end
          FN_SRL:          begin d_alu = ALU_SRL;  r_alu = 1'b1; d_alusrc = 2'd2; end
          FN_JR:           d_jr = 1'b1;
          default:         d_ill = 1'b1;
        endcase
        if (r_alu) begin
          d_regdst = 2'd1;
          d_regwr  = 1'b1;
        end
      end
      OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU, OP_LUI: begin
        d_alusrc = 2'd1;
        d_regwr  = 1'b1;
        case (op)
          OP_ANDI:  d_alu = ALU_AND;
          OP_ORI:   d_alu = ALU_OR;
          OP_XORI:  d_alu = ALU_XOR;
          OP_SLTI:  d_alu = ALU_SLT;
          OP_SLTIU: d_alu = ALU_SLTU;
          default:  d_alu = ALU_ADD;
        endcase
      end
      OP_LW: begin
        d_alusrc   = 2'd1;
        d_dren     = 1'b1;
        d_memtoreg = 2'd1;
        d_regwr    = 1'b1;
      end
      OP_SW: begin
        d_alusrc = 2'd1;
        d_dwen   = 1'b1;
      end
      OP_BEQ: begin d_alu = ALU_SUB; d_br = 1'b1; end
      OP_BNE: begin d_alu = ALU_SUB; d_br = 1'b1; d_bne = 1'b1; end
      OP_J:   d_jump = 1'b1;
      OP_JAL: begin
        d_jump     = 1'b1;
        d_regdst   = 2'd2;
        d_memtoreg = 2'd2;
        d_regwr    = 1'b1;
      end
      OP_HALT: begin
        // HALT issues as an all-zero NOP bundle (sll $0,$0,0)
        d_halt  = 1'b1;
        d_alu   = ALU_SLL;
        d_rs    = '0;
        d_rt    = '0;
        d_rd    = '0;
        d_shamt = '0;
        d_jaddr = '0;
        d_imm   = '0;
      end
      default: d_ill = 1'b1;
    endcase
  end

  assign uses_rt   = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  assign hazard    = (HAZARD_EN != 0) && ex_memread && (ex_dst != '0) && in_valid &&
                     ((ex_dst == f_rs) || (uses_rt && (ex_dst == f_rt)));
  assign held      = out_valid && !out_ready;
  assign out_free  = !held;
  assign in_ready  = nRST && (state == RUN) && !hazard && out_free && !flush;
  assign accept    = in_valid && in_ready;
  assign flush_eff = flush && ((state != DRAIN) || held);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      cnt       <= '0;
      halt      <= 1'b0;
      out_valid <= 1'b0;
      rs        <= '0;
      rt        <= '0;
      rd        <= '0;
      shamt     <= '0;
      imm32     <= '0;
      jaddr     <= '0;
      ALUctr    <= '0;
      ALUSrc    <= '0;
      RegDst    <= '0;
      MemToReg  <= '0;
      RegWr     <= 1'b0;
      dREN      <= 1'b0;
      dWEN      <= 1'b0;
      Jump      <= 1'b0;
      JumpReg   <= 1'b0;
      Branch    <= 1'b0;
      BranchNEQ <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (accept && d_halt) begin
            state <= DRAIN;
            cnt   <= 4'(DRAIN_CYCLES);
          end else if (hazard && !flush && out_free && (LU_BUBBLES > 1)) begin
            // the hazard cycle itself yields the first bubble; STALL covers the rest
            state <= STALL;
            cnt   <= 4'(LU_BUBBLES - 2);
          end
        end
        STALL: begin
          if (flush || (cnt == '0)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DRAIN: begin
          if (flush && held) begin
            state <= RUN;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= HALTED;
            halt  <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase

      if (flush_eff) begin
        out_valid <= 1'b0;
      end else if (out_free) begin
        out_valid <= accept;
        if (accept) begin
          rs        <= d_rs;
          rt        <= d_rt;
          rd        <= d_rd;
          shamt     <= d_shamt;
          imm32     <= d_imm;
          jaddr     <= d_jaddr;
          ALUctr    <= d_alu;
          ALUSrc    <= d_alusrc;
          RegDst    <= d_regdst;
          MemToReg  <= d_memtoreg;
          RegWr     <= d_regwr;
          dREN      <= d_dren;
          dWEN      <= d_dwen;
          Jump      <= d_jump;
          JumpReg   <= d_jr;
          Branch    <= d_br;
          BranchNEQ <= d_bne;
          illegal   <= d_ill;
        end
      end
    end
  end

endmodule
